granule_sample_writer: RTL and testbench



---
 rtl/granule_sample_writer.sv | 140 ++++++++++++++
 tb/tb_granule_sample_writer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/granule_sample_writer.sv
// Writes decoded big_values pairs as consecutive samples into the granule RAM, then zero-fills to 576.
// Latency: x is written the cycle after acceptance and y the cycle after that. done follows the last write by one cycle.
// Backpressure: in_ready is high only while waiting for a pair. A pair offered at any other time is dropped and flags err.
module granule_sample_writer #(
  parameter int SAMPLES   = 576,
  parameter int ADDR_W    = 10,
  parameter int MAX_PAIRS = 288
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8:0]          big_values,
  input  logic                axiiv,
  input  logic signed [15:0]  x_val,
  input  logic signed [15:0]  y_val,
  output logic                in_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic signed [15:0]  wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE_Y, FILL, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLES - 1);
  localparam logic [8:0]        MAX_BV    = 9'(MAX_PAIRS);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt, addr_inc;
  logic [8:0]          pair_cnt, pair_cnt_nxt;
  logic [8:0]          bv, bv_nxt;
  logic signed [15:0]  y_hold, y_hold_nxt;
  logic                wr_en_nxt;
  logic [ADDR_W-1:0]   wr_addr_nxt;
  logic signed [15:0]  wr_data_nxt;
  logic                err_nxt;
  logic                at_last;

  assign in_ready = (state == RECV);
  // done is registered so the pulse lands after the final write is visible; busy covers that cycle too.
  assign busy     = (state != IDLE) || done;
  assign at_last  = (addr == LAST_ADDR);
  // The address saturates at the last sample rather than wrapping.
  assign addr_inc = at_last ? addr : addr + ADDR_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state, write-port and bookkeeping decode.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    pair_cnt_nxt = pair_cnt;
    bv_nxt       = bv;
    y_hold_nxt   = y_hold;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    err_nxt      = err;
    case (state)
      IDLE: begin
        // A start landing on the done cycle still counts as busy and is ignored.
        if (start && !done) begin
          addr_nxt     = '0;
          pair_cnt_nxt = '0;
          err_nxt      = (big_values > MAX_BV);
          bv_nxt       = (big_values > MAX_BV) ? MAX_BV : big_values;
          state_nxt    = (big_values == 9'd0) ? FILL : RECV;
        end
      end
      RECV: begin
        if (axiiv) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = addr;
          wr_data_nxt = x_val;
          y_hold_nxt  = y_val;
          addr_nxt    = addr_inc;
          state_nxt   = WRITE_Y;
        end
      end
      WRITE_Y: begin
        wr_en_nxt    = 1'b1;
        wr_addr_nxt  = addr;
        wr_data_nxt  = y_hold;
        addr_nxt     = addr_inc;
        pair_cnt_nxt = pair_cnt + 9'd1;
        // A full region ends exactly on the last sample, so there is nothing to fill.
        if (at_last)                       state_nxt = DONE;
        else if (pair_cnt + 9'd1 == bv)    state_nxt = FILL;
        else                               state_nxt = RECV;
      end
      FILL: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = addr;
        wr_data_nxt = '0;
        addr_nxt    = addr_inc;
        if (at_last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A pair offered while not ready is lost; flag it after any start-time clear.
    if (axiiv && !in_ready) err_nxt = 1'b1;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      pair_cnt <= '0;
      bv       <= '0;
      y_hold   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      addr     <= addr_nxt;
      pair_cnt <= pair_cnt_nxt;
      bv       <= bv_nxt;
      y_hold   <= y_hold_nxt;
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      err      <= err_nxt;
      done     <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_granule_sample_writer.sv
// Directed bench for granule_sample_writer: every write is checked against a per-granule expected image.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
// Cycle numbers are counts of rising edges, so offsets from the start edge match the documented timing.
module tb_granule_sample_writer;

  logic        clk = 1'b0;
  logic        rst, start, axiiv;
  logic [8:0]  big_values;
  logic [15:0] x_val, y_val;
  logic        in_ready, wr_en, busy, done, err;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  granule_sample_writer dut (
    .clk(clk), .rst(rst), .start(start), .big_values(big_values),
    .axiiv(axiiv), .x_val(x_val), .y_val(y_val), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  int          cyc = 0;
  bit          mon_on = 1'b0;
  int          nxt_addr, wcount, done_cnt, done_cyc, busy_last, acc_cnt, ir_cnt, nz_cnt;
  int          start_edge;
  int          wcyc [576];
  logic [15:0] exp_data [576];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: writes must be consecutive from address 0 and match the expected image.
  always @(negedge clk) begin
    if (mon_on) begin
      if (wr_en) begin
        check("wr_addr", 32'(wr_addr), nxt_addr);
        if (nxt_addr < 576) begin
          check("wr_data", 32'(wr_data), 32'(exp_data[nxt_addr]));
          wcyc[nxt_addr] = cyc;
        end
        if (wr_data != 16'd0) nz_cnt++;
        nxt_addr++;
        wcount++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_last = cyc;
      if (in_ready) ir_cnt++;
      if (in_ready && axiiv) acc_cnt++;
    end
  end

  task automatic clear_exp();
    for (int i = 0; i < 576; i++) exp_data[i] = 16'd0;
  endtask

  // Called at rising edge + 2; start is sampled at the next rising edge.
  task automatic start_granule(input logic [8:0] n);
    start = 1'b1;
    big_values = n;
    start_edge = cyc + 1;
    nxt_addr = 0; wcount = 0; done_cnt = 0; done_cyc = 0;
    busy_last = 0; acc_cnt = 0; ir_cnt = 0; nz_cnt = 0;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Called at rising edge + 2; holds the pair until accepted, returns at accept edge + 2.
  task automatic send_pair(input logic [15:0] x, input logic [15:0] y);
    bit ok;
    ok = 1'b0;
    x_val = x; y_val = y; axiiv = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("pair_accepted", 32'(ok), 1);
    @(posedge clk); #2;
    axiiv = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) break;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    int k;
    int guard;
    int w;
    bit found;

    rst = 1'b0; start = 1'b0; axiiv = 1'b0; big_values = '0; x_val = '0; y_val = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #2;
    rst = 1'b1;
    mon_on = 1'b1;
    @(posedge clk); #2;

    // Empty region: 576 zero writes with exact cycle placement.
    clear_exp();
    start_granule(9'd0);
    wait_done();
    check("t1_first_write_ofs", wcyc[0] - start_edge, 1);
    check("t1_last_write_ofs", wcyc[575] - start_edge, 576);
    check("t1_done_ofs", done_cyc - start_edge, 577);
    check("t1_busy_last_ofs", busy_last - start_edge, 577);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_wcount", wcount, 576);
    check("t1_err", 32'(err), 0);

    // Two pairs with idle gaps, negative values passed through.
    clear_exp();
    exp_data[0] = 16'd3; exp_data[1] = 16'hFFFB; exp_data[2] = 16'hFFB2; exp_data[3] = 16'd15;
    @(posedge clk); #2;
    start_granule(9'd2);
    repeat (3) @(posedge clk); #2;
    send_pair(16'd3, 16'hFFFB);
    repeat (3) @(posedge clk); #2;
    send_pair(16'hFFB2, 16'd15);
    wait_done();
    check("t2_done_cnt", done_cnt, 1);
    check("t2_wcount", wcount, 576);
    check("t2_fill_span", wcyc[575] - wcyc[3], 572);
    check("t2_done_after_last", done_cyc - wcyc[575], 1);
    check("t2_busy_fall", busy_last, done_cyc);
    check("t2_err", 32'(err), 0);
    check("t2_accepted", acc_cnt, 2);

    // Full region with axiiv held high: one pair per two cycles, no fill.
    clear_exp();
    for (int i = 0; i < 576; i++) exp_data[i] = 16'(i + 1);
    @(posedge clk); #2;
    start_granule(9'd288);
    k = 0; guard = 0;
    x_val = 16'd1; y_val = 16'd2; axiiv = 1'b1;
    while (k < 288 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        @(posedge clk); #2;
        k++;
        x_val = 16'(2 * k + 1);
        y_val = 16'(2 * k + 2);
      end
    end
    axiiv = 1'b0;
    check("t3_pairs_sent", k, 288);
    wait_done();
    check("t3_in_ready_cycles", ir_cnt, 288);
    check("t3_nonzero_writes", nz_cnt, 576);
    check("t3_back_to_back", wcyc[575] - wcyc[0], 575);
    check("t3_done_after_575", done_cyc - wcyc[575], 1);
    check("t3_done_ofs", done_cyc - start_edge, 577);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_err_from_held_axiiv", 32'(err), 1);

    // Oversized big_values: clamped to 288 pairs with err raised at start.
    clear_exp();
    for (int i = 0; i < 288; i++) begin
      exp_data[2 * i]     = 16'(i + 1);
      exp_data[2 * i + 1] = 16'(1000 + i);
    end
    @(posedge clk); #2;
    start_granule(9'd300);
    @(negedge clk); #1;
    check("t4_err_at_start", 32'(err), 1);
    @(posedge clk); #2;
    for (int i = 0; i < 288; i++) send_pair(16'(i + 1), 16'(1000 + i));
    x_val = 16'd77; y_val = 16'd77; axiiv = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    axiiv = 1'b0;
    wait_done();
    check("t4_accepted", acc_cnt, 288);
    check("t4_wcount", wcount, 576);
    check("t4_done_after_575", done_cyc - wcyc[575], 1);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_err", 32'(err), 1);

    // Drops during WRITE_Y and FILL, plus a start while busy: sequence unchanged, err sticky.
    clear_exp();
    exp_data[0] = 16'd7; exp_data[1] = 16'hFFF9;
    @(posedge clk); #2;
    start_granule(9'd1);
    @(negedge clk); #1;
    check("t5_err_cleared", 32'(err), 0);
    @(posedge clk); #2;
    x_val = 16'd7; y_val = 16'hFFF9; axiiv = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #2;
    x_val = 16'd99; y_val = 16'd99;
    @(posedge clk); #2;
    axiiv = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    axiiv = 1'b1; start = 1'b1; big_values = 9'd0;
    @(posedge clk); #2;
    axiiv = 1'b0; start = 1'b0;
    wait_done();
    check("t5_accepted", acc_cnt, 1);
    check("t5_wcount", wcount, 576);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_err_sticky", 32'(err), 1);

    // Reset in the middle of the fill aborts everything; next granule restarts at 0.
    clear_exp();
    @(posedge clk); #2;
    start_granule(9'd0);
    repeat (5) @(posedge clk);
    #2;
    axiiv = 1'b1;
    @(posedge clk); #2;
    axiiv = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 10'd100) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_100", 32'(found), 1);
    check("t6_err_before_rst", 32'(err), 1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_wr_en", 32'(wr_en), 0);
    check("t6_rst_wr_addr", 32'(wr_addr), 0);
    check("t6_rst_wr_data", 32'(wr_data), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_err", 32'(err), 0);
    check("t6_rst_in_ready", 32'(in_ready), 0);
    w = wcount;
    repeat (20) @(negedge clk);
    #1;
    check("t6_no_writes_in_rst", wcount, w);
    check("t6_no_done", done_cnt, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    clear_exp();
    exp_data[0] = 16'd5; exp_data[1] = 16'd6;
    start_granule(9'd1);
    repeat (2) @(posedge clk);
    #2;
    send_pair(16'd5, 16'd6);
    wait_done();
    check("t6_restart_wcount", wcount, 576);
    check("t6_restart_done_cnt", done_cnt, 1);
    check("t6_restart_err", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
